// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline hazard handshake bundle between datapath and stall controller
//
// Groups the Decode/Execute/Memory hazard inputs and the stall/flush/statistics
// outputs of hazard_stall_ctrl.
//   master : pipeline side, drives hazard sources, receives stall/flush controls
//   slave  : controller side (hazard_stall_ctrl)
// CNT_W must match the CNT_W of the controller instance it connects to.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  // Decode / Execute / Memory hazard sources
  logic [3:0]       ID_rs;
  logic [3:0]       ID_rt;
  logic             ID_uses_rt;
  logic             ID_EX_mem_read;
  logic [3:0]       ID_EX_rd;
  logic             EX_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  // Pipeline controls
  logic             PC_stall;
  logic             IF_ID_stall;
  logic             IF_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_stall;
  logic             mem_timeout;

  // Event statistics
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mw_cnt;

  modport master (
    output ID_rs, ID_rt, ID_uses_rt, ID_EX_mem_read, ID_EX_rd,
           EX_branch_taken, mem_req, mem_ready,
    input  PC_stall, IF_ID_stall, IF_flush, ID_EX_flush, EX_MEM_stall,
           mem_timeout, lu_cnt, br_cnt, mw_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rt, ID_EX_mem_read, ID_EX_rd,
           EX_branch_taken, mem_req, mem_ready,
    output PC_stall, IF_ID_stall, IF_flush, ID_EX_flush, EX_MEM_stall,
           mem_timeout, lu_cnt, br_cnt, mw_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard detection with memory-wait FSM and timeout
//
// Resolves three hazard sources with priority memory-stall > taken branch > load-use:
//   - memory stall : freezes the whole pipeline while the data memory is not ready
//   - taken branch : squashes Fetch and Decode (IF_flush, ID_EX_flush)
//   - load-use     : holds PC and IF/ID and injects a bubble into ID/EX
// A memory access that stays unanswered for more than MEM_TIMEOUT wait cycles
// locks the FSM in TIMEOUT (sticky mem_timeout, all stalls held) until rst.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; also forces all stall/flush outputs low
//   hz   - hazard_stall_ctrl_if.slave: hazard inputs, stall/flush outputs,
//          registered mem_timeout, lu_cnt/br_cnt/mw_cnt statistics
//
// Configuration:
//   HAZARD_STATS_EN - when defined, saturating event counters are built;
//                     otherwise the counter outputs are tied to zero.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave hz
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nx;
  logic       mem_timeout_q;

  logic       mstall;
  logic       load_use;
  logic       br_resp;
  logic       lu_resp;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      wait_cnt      <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state_nx == TIMEOUT)
        mem_timeout_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_nx    = MEM_WAIT;
          wait_cnt_nx = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_nx    = RUN;
          wait_cnt_nx = 8'd0;
        end else if (wait_cnt < TMO) begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end else begin
          state_nx = TIMEOUT;
        end
      end
      TIMEOUT: state_nx = TIMEOUT;
      default: begin
        state_nx    = RUN;
        wait_cnt_nx = 8'd0;
      end
    endcase
  end

  // Output logic; rst gates everything so an asserted reset releases a
  // frozen pipeline immediately, without waiting for a clock edge.
  always_comb begin
    mstall = 1'b0;
    if (!rst) begin
      case (state)
        RUN:      mstall = hz.mem_req && !hz.mem_ready;
        MEM_WAIT: mstall = !hz.mem_ready;
        TIMEOUT:  mstall = 1'b1;
        default:  mstall = 1'b0;
      endcase
    end

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    load_use = hz.ID_EX_mem_read && (hz.ID_EX_rd != 4'd0) &&
               ((hz.ID_EX_rd == hz.ID_rs) ||
                (hz.ID_uses_rt && (hz.ID_EX_rd == hz.ID_rt)));

    // Execute is frozen during mstall and will re-present the branch later.
    br_resp = !rst && !mstall && hz.EX_branch_taken;
    lu_resp = !rst && !mstall && !hz.EX_branch_taken && load_use;

    hz.PC_stall     = mstall || lu_resp;
    hz.IF_ID_stall  = mstall || lu_resp;
    hz.IF_flush     = br_resp;
    hz.ID_EX_flush  = br_resp || lu_resp;
    hz.EX_MEM_stall = mstall;
  end

  assign hz.mem_timeout = mem_timeout_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_q;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mw_q;

  // Saturating event counters, one increment per qualifying cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_q <= '0;
      br_q <= '0;
      mw_q <= '0;
    end else begin
      if (lu_resp && (lu_q != {CNT_W{1'b1}}))
        lu_q <= lu_q + 1'b1;
      if (br_resp && (br_q != {CNT_W{1'b1}}))
        br_q <= br_q + 1'b1;
      if (mstall && (mw_q != {CNT_W{1'b1}}))
        mw_q <= mw_q + 1'b1;
    end
  end

  assign hz.lu_cnt = lu_q;
  assign hz.br_cnt = br_q;
  assign hz.mw_cnt = mw_q;
`else
  assign hz.lu_cnt = {CNT_W{1'b0}};
  assign hz.br_cnt = {CNT_W{1'b0}};
  assign hz.mw_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, SHALL set the number of consecutive memory-stall cycles tolerated before timeout (range 1..255).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the statistics counters.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ID_rs  in  4  source register 1 of the instruction in Decode.
REQ-006 ID_rt  in  4  source register 2 of the instruction in Decode.
REQ-007 ID_uses_rt  in  1  Decode instruction reads ID_rt.
REQ-008 ID_EX_mem_read  in  1  instruction in Execute is a load.
REQ-009 ID_EX_rd  in  4  destination register of the instruction in Execute.
REQ-010 EX_branch_taken  in  1  branch resolved taken in Execute this cycle.
REQ-011 mem_req  in  1  Memory stage issues a data access this cycle.
REQ-012 mem_ready  in  1  data memory completes the access this cycle.
REQ-013 PC_stall  out  1  hold the PC.
REQ-014 IF_ID_stall  out  1  hold the IF/ID register.
REQ-015 IF_flush  out  1  squash the instruction in Fetch.
REQ-016 ID_EX_flush  out  1  load a bubble into ID/EX.
REQ-017 EX_MEM_stall  out  1  hold ID/EX and EX/MEM (back-end freeze).
REQ-018 mem_timeout  out  1  sticky memory-timeout error flag.
REQ-019 lu_cnt, br_cnt, mw_cnt  out  CNT_W each  load-use, branch-flush and memory-stall event counters.

Function
REQ-020 The FSM SHALL have three states: RUN, MEM_WAIT and TIMEOUT.
REQ-021 mstall SHALL be 1 when (RUN and mem_req and !mem_ready), or (MEM_WAIT and !mem_ready), or TIMEOUT.
REQ-022 mstall=1 SHALL assert PC_stall, IF_ID_stall and EX_MEM_stall, and SHALL hold IF_flush and ID_EX_flush at 0.
REQ-023 In RUN, mem_req and !mem_ready SHALL move the FSM to MEM_WAIT and load wait_cnt=1.
REQ-024 In MEM_WAIT, mem_ready=1 SHALL drop all stalls in that same cycle and return the FSM to RUN on the next edge.
REQ-025 In MEM_WAIT, mem_ready=0 with wait_cnt<MEM_TIMEOUT SHALL increment wait_cnt.
REQ-026 In MEM_WAIT, mem_ready=0 with wait_cnt==MEM_TIMEOUT SHALL move the FSM to TIMEOUT.
REQ-027 TIMEOUT SHALL set mem_timeout=1 and hold all stalls until rst.
REQ-028 Branch, when mstall=0 and EX_branch_taken=1, SHALL assert IF_flush=1 and ID_EX_flush=1 for one cycle, with PC_stall=0 and IF_ID_stall=0.
REQ-029 Load-use SHALL be detected as ID_EX_mem_read and ID_EX_rd!=0 and (ID_EX_rd==ID_rs or (ID_uses_rt and ID_EX_rd==ID_rt)).
REQ-030 Load-use, when mstall=0 and branch=0, SHALL assert PC_stall=1, IF_ID_stall=1 and ID_EX_flush=1 for that cycle; the FSM stays in RUN.
REQ-031 Priority SHALL be mstall > branch > load-use; a branch coincident with load-use SHALL produce the branch response only.
REQ-032 EX_branch_taken SHALL be ignored while mstall=1, since Execute is frozen and re-presents the branch.
REQ-033 Stall and flush outputs SHALL be combinational from the FSM state and the inputs; mem_timeout SHALL be registered.

Reset
REQ-034 While rst is asserted: FSM=RUN, wait_cnt=0, mem_timeout=0, all counters 0.
REQ-035 While rst is asserted, all stall and flush outputs SHALL be 0.
REQ-036 rst asserted during MEM_WAIT or TIMEOUT SHALL release all stalls immediately and asynchronously.

Configuration
REQ-037 With HAZARD_STATS_EN defined, the counters SHALL increment by 1 per cycle as follows, saturating at all-ones: lu_cnt on a load-use response, br_cnt on a branch response, mw_cnt on mstall=1.
REQ-038 Without HAZARD_STATS_EN, lu_cnt, br_cnt and mw_cnt SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-039 Load-use: ID_EX_mem_read=1, ID_EX_rd=3, ID_rs=3 for one cycle -> PC_stall=IF_ID_stall=ID_EX_flush=1 that cycle only; lu_cnt=1.
REQ-040 Zero-register and unused rt: ID_EX_rd=0 matching ID_rs, or ID_EX_rd=5 matching ID_rt with ID_uses_rt=0 -> no stall.
REQ-041 Branch coincident with load-use -> IF_flush=ID_EX_flush=1 and PC_stall=0; br_cnt=1 and lu_cnt=0.
REQ-042 Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> EX_MEM_stall high for exactly 3 cycles, FSM back in RUN; mw_cnt=3.
REQ-043 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 5 stall cycles and stalls persist; rst pulse -> all outputs 0.
REQ-044 Saturation: CNT_W=4 with 20 load-use cycles -> lu_cnt=15; with HAZARD_STATS_EN undefined -> all counters 0.
